// File: rtl/fifo_flex_pkg.sv
// Shared types and helpers for the fifo_flex buffer: read-mode enum, flag struct
// and the flag decode used on the registered occupancy count.
package fifo_flex_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;
  localparam int unsigned CNT_W          = DEF_ADDR_WIDTH + 1;

  typedef enum logic {
    RD_REG  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic af;
    logic ae;
  } fifo_flags_t;

  // All status flags come from one count value, so full and empty are exclusive.
  function automatic fifo_flags_t fifo_flags_f(input int unsigned count,
                                               input int unsigned depth,
                                               input int unsigned af_level,
                                               input int unsigned ae_level);
    fifo_flags_t f;
    f.full  = (count == depth);
    f.empty = (count == 0);
    f.af    = (count >= af_level);
    f.ae    = (count <= ae_level);
    return f;
  endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// Storage array for fifo_flex: one synchronous write port, one asynchronous
// read port, no reset on the contents.
module fifo_flex_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with occupancy count, almost thresholds, registered or
// first-word-fall-through read, synchronous flush and sticky error flags.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned FIFO_DEPTH = 2 ** ADDR_WIDTH;
  localparam rd_mode_e    RD_MODE    = (FWFT != 0) ? RD_FWFT : RD_REG;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc;
  fifo_flags_t           flags;

  assign flags  = fifo_flags_f(32'(cnt_q), FIFO_DEPTH, AF_LEVEL, AE_LEVEL);
  // Flush wins over both requests, so nothing is accepted in a flush cycle.
  assign wr_acc = wr_en & ~flags.full  & ~flush;
  assign rd_acc = rd_en & ~flags.empty & ~flush;

  fifo_flex_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rdata_d  = mem_rdata;
        rvalid_d = 1'b1;
      end
      if (wr_acc && !rd_acc)      cnt_d = cnt_q + 1'b1;
      else if (rd_acc && !wr_acc) cnt_d = cnt_q - 1'b1;
    end
    // A new error in the clr_err cycle still leaves the flag set.
    ovf_d = (ovf_q & ~clr_err) | (~flush & wr_en & flags.full);
    unf_d = (unf_q & ~clr_err) | (~flush & rd_en & flags.empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign rdata        = (RD_MODE == RD_FWFT) ? mem_rdata : rdata_q;
  assign rvalid       = (RD_MODE == RD_FWFT) ? ~flags.empty : rvalid_q;
  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.af;
  assign almost_empty = flags.ae;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a registered-read instance and an FWFT instance driven
// by directed vectors; read data is checked by monitors against expected queues.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic reset;

  logic       flush_0, wr_en_0, rd_en_0, clr_err_0;
  logic [7:0] wdata_0, rdata_0;
  logic       rvalid_0, full_0, empty_0, af_0, ae_0, ovf_0, unf_0;
  logic [3:0] count_0;

  logic       flush_1, wr_en_1, rd_en_1, clr_err_1;
  logic [7:0] wdata_1, rdata_1;
  logic       rvalid_1, full_1, empty_1, af_1, ae_1, ovf_1, unf_1;
  logic [3:0] count_1;

  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_flex #(.FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush_0), .wr_en(wr_en_0), .wdata(wdata_0),
    .rd_en(rd_en_0), .rdata(rdata_0), .rvalid(rvalid_0), .full(full_0),
    .empty(empty_0), .almost_full(af_0), .almost_empty(ae_0), .count(count_0),
    .overflow(ovf_0), .underflow(unf_0), .clr_err(clr_err_0)
  );

  fifo_flex #(.FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush_1), .wr_en(wr_en_1), .wdata(wdata_1),
    .rd_en(rd_en_1), .rdata(rdata_1), .rvalid(rvalid_1), .full(full_1),
    .empty(empty_1), .almost_full(af_1), .almost_empty(ae_1), .count(count_1),
    .overflow(ovf_1), .underflow(unf_1), .clr_err(clr_err_1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write0(input logic [7:0] d);
    wr_en_0 = 1'b1;
    wdata_0 = d;
    tick();
    wr_en_0 = 1'b0;
  endtask

  task automatic read0(input logic [7:0] exp);
    rd_en_0 = 1'b1;
    exp0_q.push_back(exp);
    tick();
    rd_en_0 = 1'b0;
  endtask

  // Registered mode: every rvalid pulse must carry the oldest expected word.
  always @(negedge clk) begin
    if (!reset && rvalid_0) begin
      if (exp0_q.size() == 0) check("rdata0_unexpected", 32'(rdata_0), 32'hFFFF_FFFF);
      else check("rdata0", 32'(rdata_0), 32'(exp0_q.pop_front()));
    end
  end

  // FWFT mode: the word on rdata is the one consumed when rd_en is high.
  always @(negedge clk) begin
    if (!reset && rvalid_1 && rd_en_1) begin
      if (exp1_q.size() == 0) check("rdata1_unexpected", 32'(rdata_1), 32'hFFFF_FFFF);
      else check("rdata1", 32'(rdata_1), 32'(exp1_q.pop_front()));
    end
  end

  initial begin
    reset = 1'b1;
    {flush_0, wr_en_0, rd_en_0, clr_err_0} = '0;
    {flush_1, wr_en_1, rd_en_1, clr_err_1} = '0;
    wdata_0 = '0;
    wdata_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count_0), 0);
    check("rst_flags", 32'({full_0, empty_0, af_0, ae_0}), 32'b0101);
    check("rst_err", 32'({ovf_0, unf_0}), 0);
    check("rst_rvalid", 32'(rvalid_0), 0);
    check("rst_rdata", 32'(rdata_0), 0);
    reset = 1'b0;
    tick();

    // Fill with thresholds tracked on every step
    for (int i = 0; i < 8; i++) begin
      write0(8'h10 + 8'(i));
      check("fill_count", 32'(count_0), i + 1);
      check("fill_af", 32'(af_0), 32'((i + 1) >= 6));
      check("fill_ae", 32'(ae_0), 32'((i + 1) <= 2));
    end
    check("fill_full", 32'({full_0, empty_0}), 32'b10);

    for (int i = 0; i < 8; i++) begin
      read0(8'h10 + 8'(i));
      check("drain_ae", 32'(ae_0), 32'((7 - i) <= 2));
    end
    tick();
    check("drain_empty", 32'({full_0, empty_0, 4'(count_0)}), 32'b01_0000);

    // Wrap-around: 15 more words moves both pointers to 7
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) write0(8'h20 + 8'(k * 5 + j));
      for (int j = 0; j < 5; j++) read0(8'h20 + 8'(k * 5 + j));
    end
    tick();
    check("wrap_count", 32'(count_0), 0);
    check("wrap_wr_ptr", 32'(dut0.wr_ptr_q), 7);
    check("wrap_rd_ptr", 32'(dut0.rd_ptr_q), 7);

    // Full with both requests: read wins, write rejected, overflow set
    for (int i = 0; i < 8; i++) write0(8'h30 + 8'(i));
    wr_en_0 = 1'b1; rd_en_0 = 1'b1; wdata_0 = 8'hEE;
    exp0_q.push_back(8'h30);
    tick();
    wr_en_0 = 1'b0; rd_en_0 = 1'b0;
    check("full_both_count", 32'(count_0), 7);
    check("full_both_ovf", 32'(ovf_0), 1);
    for (int i = 1; i < 8; i++) read0(8'h30 + 8'(i));
    tick();
    check("full_both_empty", 32'(empty_0), 1);

    // Empty with both requests: write wins, read rejected, underflow set
    wr_en_0 = 1'b1; rd_en_0 = 1'b1; wdata_0 = 8'h44;
    tick();
    wr_en_0 = 1'b0; rd_en_0 = 1'b0;
    check("empty_both_count", 32'(count_0), 1);
    check("empty_both_unf", 32'(unf_0), 1);
    read0(8'h44);
    tick();

    // clr_err racing a new underflow keeps it set; plain clr_err clears both
    clr_err_0 = 1'b1; rd_en_0 = 1'b1;
    tick();
    rd_en_0 = 1'b0;
    check("clr_race_unf", 32'(unf_0), 1);
    check("clr_race_ovf", 32'(ovf_0), 0);
    tick();
    clr_err_0 = 1'b0;
    check("clr_err", 32'({ovf_0, unf_0}), 0);

    // Flush at count 5 with a concurrent write
    for (int i = 0; i < 5; i++) write0(8'h50 + 8'(i));
    check("pre_flush_count", 32'(count_0), 5);
    flush_0 = 1'b1; wr_en_0 = 1'b1; wdata_0 = 8'h99;
    tick();
    flush_0 = 1'b0; wr_en_0 = 1'b0;
    check("flush_count", 32'(count_0), 0);
    check("flush_empty", 32'(empty_0), 1);
    check("flush_ovf", 32'(ovf_0), 0);

    // Flush while full with wr_en: no new error, existing overflow kept
    for (int i = 0; i < 8; i++) write0(8'h60 + 8'(i));
    write0(8'h70);
    check("ovf_set", 32'(ovf_0), 1);
    flush_0 = 1'b1; wr_en_0 = 1'b1;
    tick();
    flush_0 = 1'b0; wr_en_0 = 1'b0;
    check("flush_full_count", 32'(count_0), 0);
    check("flush_keep_ovf", 32'(ovf_0), 1);
    clr_err_0 = 1'b1;
    tick();
    clr_err_0 = 1'b0;

    // Async reset mid-burst with underflow pending
    rd_en_0 = 1'b1;
    tick();
    rd_en_0 = 1'b0;
    check("unf_set", 32'(unf_0), 1);
    for (int i = 0; i < 3; i++) write0(8'h80 + 8'(i));
    wr_en_0 = 1'b1; wdata_0 = 8'h83;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_count", 32'(count_0), 0);
    check("async_flags", 32'({full_0, empty_0, af_0, ae_0}), 32'b0101);
    check("async_err", 32'({ovf_0, unf_0}), 0);
    check("async_rd", 32'({rvalid_0, rdata_0}), 0);
    wr_en_0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // FWFT instance
    check("fwft_idle", 32'({rvalid_1, empty_1}), 32'b01);
    wr_en_1 = 1'b1; wdata_1 = 8'hA5;
    tick();
    wr_en_1 = 1'b0;
    check("fwft_rvalid", 32'(rvalid_1), 1);
    check("fwft_rdata", 32'(rdata_1), 32'hA5);
    tick();
    check("fwft_hold", 32'({rvalid_1, rdata_1}), 32'h1A5);
    rd_en_1 = 1'b1;
    exp1_q.push_back(8'hA5);
    tick();
    rd_en_1 = 1'b0;
    check("fwft_empty", 32'({rvalid_1, empty_1}), 32'b01);
    wr_en_1 = 1'b1; wdata_1 = 8'hB1;
    tick();
    wdata_1 = 8'hB2;
    tick();
    wr_en_1 = 1'b0;
    check("fwft_count2", 32'(count_1), 2);
    rd_en_1 = 1'b1;
    exp1_q.push_back(8'hB1);
    exp1_q.push_back(8'hB2);
    tick();
    tick();
    rd_en_1 = 1'b0;
    check("fwft_drained", 32'({rvalid_1, empty_1}), 32'b01);

    repeat (2) tick();
    check("exp0_left", 32'(exp0_q.size()), 0);
    check("exp1_left", 32'(exp1_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
